// File: rtl/pingpong_sample_ram.sv
// -----------------------------------------------------------------------------
// pingpong_sample_ram
//
// Double-buffered multi-channel sample store. The ADC side streams packed
// samples into the bank it owns. The processing side reads the last completed
// bank through two independent synchronous read ports. A bank passes to the
// reader when its frame completes, and returns to the writer on rd_done.
// Samples that arrive while the writer's bank is still held by the reader are
// dropped and counted.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid, in_data      sample strobe (no back-pressure), packed sample
//                          (channel 0 in the LSBs)
//   rd_valid, rd_bank      reader owns a completed bank / index of that bank
//   rd_addr_a, rd_addr_b   read addresses, ports A and B
//   rd_dout_a, rd_dout_b   read data, one cycle after the address
//   rd_done                single-cycle pulse that releases the reader's bank
//   wr_bank, wr_ptr        bank being filled / next write address in it
//   frame_cnt              completed frames, wraps
//   overflow, drop_cnt     sticky drop flag / saturating drop count
//   ovf_clr                clears overflow and drop_cnt
// -----------------------------------------------------------------------------
module pingpong_sample_ram #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 12,
  parameter int CH        = 2,
  parameter int FRAME_LEN = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 rd_valid,
  output logic                 rd_bank,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [CH*DATA_W-1:0] rd_dout_a,
  output logic [CH*DATA_W-1:0] rd_dout_b,
  input  logic                 rd_done,
  output logic                 wr_bank,
  output logic [ADDR_W-1:0]    wr_ptr,
  output logic [15:0]          frame_cnt,
  output logic                 overflow,
  output logic [15:0]          drop_cnt,
  input  logic                 ovf_clr
);

  localparam int W     = CH * DATA_W;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  // Both banks in one array, indexed {bank, addr}.
  logic [W-1:0]      mem_r [0:2*DEPTH-1];

  logic              wr_bank_r;
  logic              rd_bank_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [1:0]        full_r;
  logic [15:0]       frame_cnt_r;
  logic              overflow_r;
  logic [15:0]       drop_cnt_r;
  logic [W-1:0]      dout_a_r;
  logic [W-1:0]      dout_b_r;

  logic              wr_full_s;
  logic              wr_en_s;
  logic              drop_s;
  logic              frame_end_s;
  logic              release_s;
  logic [1:0]        full_nxt_s;
  logic [ADDR_W-1:0] wr_ptr_nxt_s;
  logic [15:0]       frame_cnt_nxt_s;
  logic              overflow_nxt_s;
  logic [15:0]       drop_cnt_nxt_s;

  // Write/release decode and next-state computation.
  always_comb begin
    wr_full_s       = full_r[wr_bank_r];
    wr_en_s         = in_valid & ~wr_full_s;
    drop_s          = in_valid & wr_full_s;
    frame_end_s     = wr_en_s & (wr_ptr_r == LAST_ADDR);
    release_s       = rd_done & full_r[rd_bank_r];
    full_nxt_s      = full_r;
    wr_ptr_nxt_s    = wr_ptr_r;
    frame_cnt_nxt_s = frame_cnt_r + {15'd0, frame_end_s};
    overflow_nxt_s  = overflow_r;
    drop_cnt_nxt_s  = drop_cnt_r;

    // Release and frame completion can never hit the same bank in one cycle:
    // the writer only completes an empty bank, the reader only releases a full
    // one. The flags are uses the full value seen at the start of the cycle,
    // so a release and a drop on the same bank both happen.
    for (int b = 0; b < 2; b++) begin
      full_nxt_s[b] = (full_r[b] & ~(release_s & (rd_bank_r == 1'(b))))
                    | (frame_end_s & (wr_bank_r == 1'(b)));
    end

    if (frame_end_s) begin
      wr_ptr_nxt_s = {ADDR_W{1'b0}};
    end else if (wr_en_s) begin
      wr_ptr_nxt_s = wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    // A drop in the same cycle as a clear restarts the count at one.
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
      if (ovf_clr) begin
        drop_cnt_nxt_s = 16'd1;
      end else if (drop_cnt_r == 16'hFFFF) begin
        drop_cnt_nxt_s = drop_cnt_r;
      end else begin
        drop_cnt_nxt_s = drop_cnt_r + 16'd1;
      end
    end else if (ovf_clr) begin
      overflow_nxt_s = 1'b0;
      drop_cnt_nxt_s = 16'd0;
    end else begin
      overflow_nxt_s = overflow_r;
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // Bank ownership, pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      wr_ptr_r    <= {ADDR_W{1'b0}};
      full_r      <= 2'b00;
      frame_cnt_r <= 16'd0;
      overflow_r  <= 1'b0;
      drop_cnt_r  <= 16'd0;
    end else begin
      wr_bank_r   <= wr_bank_r ^ frame_end_s;
      rd_bank_r   <= rd_bank_r ^ release_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      full_r      <= full_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      overflow_r  <= overflow_nxt_s;
      drop_cnt_r  <= drop_cnt_nxt_s;
    end
  end

  // Sample RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[{wr_bank_r, wr_ptr_r}] <= in_data;
    end
  end

  // Two synchronous read ports into the reader's bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_r <= {W{1'b0}};
      dout_b_r <= {W{1'b0}};
    end else begin
      dout_a_r <= mem_r[{rd_bank_r, rd_addr_a}];
      dout_b_r <= mem_r[{rd_bank_r, rd_addr_b}];
    end
  end

  assign rd_valid  = full_r[rd_bank_r];
  assign rd_bank   = rd_bank_r;
  assign wr_bank   = wr_bank_r;
  assign wr_ptr    = wr_ptr_r;
  assign frame_cnt = frame_cnt_r;
  assign overflow  = overflow_r;
  assign drop_cnt  = drop_cnt_r;
  assign rd_dout_a = dout_a_r;
  assign rd_dout_b = dout_b_r;

endmodule
